// File: rtl/ins_line_fill_pkg.sv
// Shared types and constants for the instruction-cache line-fill responder.
package ins_line_fill_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFS_W      = 2;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

  // Word slot inside the line, wrapping so a fill never leaves its 16-byte line
  function automatic logic [OFS_W-1:0] wrapSlot(input logic [OFS_W-1:0] ofs,
                                                input logic [OFS_W-1:0] n);
    return ofs + n;
  endfunction

endpackage

// File: rtl/ins_line_fill_if.sv
// Cache-side request/response and ROM-side read bundle of the line-fill responder.
interface ins_line_fill_if #(
  parameter int ADDR_W = 32
);
  import ins_line_fill_pkg::*;

  logic              ireq;
  logic [ADDR_W-1:0] iaddr;
  logic              oready;
  logic              omem_rd;
  logic [ADDR_W-1:0] omem_addr;
  logic [WORD_W-1:0] imem_data;
  logic              ocrit_valid;
  logic [WORD_W-1:0] ocrit_word;
  logic              ovalid;
  logic [LINE_W-1:0] oline;
  logic [ADDR_W-1:0] oline_addr;

  modport slave (
    input  ireq, iaddr, imem_data,
    output oready, omem_rd, omem_addr, ocrit_valid, ocrit_word, ovalid, oline, oline_addr
  );

  modport master (
    output ireq, iaddr, imem_data,
    input  oready, omem_rd, omem_addr, ocrit_valid, ocrit_word, ovalid, oline, oline_addr
  );

endinterface

// File: rtl/ins_line_fill_pipe.sv
// Tracks outstanding ROM reads: the output is high in the cycle a read's data is on the bus.
module ins_line_fill_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic rd_i,
  output logic valid_o
);

  logic [DEPTH-1:0] shift_q;

  // Clearing on reset is what drops data from reads issued before an abort
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q <= '0;
    end else begin
      shift_q <= DEPTH'({shift_q, rd_i});
    end
  end

  assign valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/ins_line_fill.sv
// Line-fill responder: critical-word-first reads of a 4-word line, early critical word, full line pulse.
module ins_line_fill
  import ins_line_fill_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  ins_line_fill_if.slave  bus
);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:4] lineBase_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [OFS_W-1:0]  issueCnt_q;
  logic [OFS_W-1:0]  retCnt_q;
  logic [LINE_W-1:0] line_q;
  logic [WORD_W-1:0] critWord_q;
  logic              critValid_q;
  logic              retValid;
  logic              accept;
  logic [OFS_W-1:0]  retSlot;

  ins_line_fill_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .rd_i    (bus.omem_rd),
    .valid_o (retValid)
  );

  assign accept  = (state_q == IDLE) && bus.ireq;
  assign retSlot = wrapSlot(ofs_q, retCnt_q);

  always_comb begin
    state_d       = state_q;
    bus.oready    = 1'b0;
    bus.omem_rd   = 1'b0;
    bus.omem_addr = '0;
    bus.ovalid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.oready = 1'b1;
        if (bus.ireq) state_d = ISSUE;
      end
      ISSUE: begin
        bus.omem_rd   = 1'b1;
        bus.omem_addr = {lineBase_q, wrapSlot(ofs_q, issueCnt_q), 2'b00};
        if (issueCnt_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (retValid && (retCnt_q == 2'd3)) state_d = DONE;
      end
      DONE: begin
        bus.ovalid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Returns come back in issue order, so a running count from the offset picks the slot
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      lineBase_q  <= '0;
      ofs_q       <= '0;
      issueCnt_q  <= '0;
      retCnt_q    <= '0;
      line_q      <= '0;
      critWord_q  <= '0;
      critValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      critValid_q <= 1'b0;
      if (accept) begin
        lineBase_q <= bus.iaddr[ADDR_W-1:4];
        ofs_q      <= bus.iaddr[3:2];
        issueCnt_q <= '0;
        retCnt_q   <= '0;
      end else if (state_q == ISSUE) begin
        issueCnt_q <= issueCnt_q + 2'd1;
      end
      if (retValid) begin
        line_q[retSlot*WORD_W +: WORD_W] <= bus.imem_data;
        retCnt_q <= retCnt_q + 2'd1;
        if (retCnt_q == 2'd0) begin
          critValid_q <= 1'b1;
          critWord_q  <= bus.imem_data;
        end
      end
    end
  end

  assign bus.ocrit_valid = critValid_q;
  assign bus.ocrit_word  = critWord_q;
  assign bus.oline       = line_q;
  assign bus.oline_addr  = {lineBase_q, 4'b0000};

endmodule
